neuron_train_ctrl: RTL
======================

# neuron_train_ctrl

Sequencing controller for the two-input `output_neuron` datapath. It loads the inputs and initial weights and clears the neuron's result and loss registers. It then repeats forward pass → error evaluation → sign-based weight update until the result is within tolerance of the target or an epoch limit is reached. It sits directly above `output_neuron`: it drives that block's enable, clear, x and w inputs and reads back its registered result.

## Interface
Parameters:
- `MAX_EPOCHS`, default 15: maximum number of weight updates before giving up. Range 1–15.
- `TOL`, default 16: convergence tolerance on |error|, in units of 2^-7.
- `STEP`, default 1: weight increment or decrement per update, in LSBs of the 1.7 weight.

Ports (clock and reset first):
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `start_i` in 1: begin a training run; sampled only in IDLE.
- `target_i` in 4: integer target, latched on start.
- `x0_i`, `x1_i` in 10 each: unsigned inputs, latched on start.
- `w0_init_i`, `w1_init_i` in 8 each: initial 1.7 weights, latched on start.
- `final_i` in 19: registered result from the neuron.
- `zero_end_check_i` in 1: neuron's "result 0 and target 0" flag.
- `en_o` out 1: neuron enable.
- `zero_final_o`, `zero_loss_o` out 1 each: neuron clears.
- `x0_o`, `x1_o` out 10 each: latched inputs to the neuron.
- `w0_o`, `w1_o` out 8 each: current weights to the neuron.
- `target_o` out 4: latched target, drives the neuron's `init_i`.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse at the end of a run.
- `converged_o` out 1: result of the last run; held until the next start.
- `epoch_o` out 4: number of updates performed; held until the next start.

## Operation
- States are IDLE, CLEAR, FWD, EVAL, UPDATE and DONE.
- IDLE: on `start_i`, do the following, then go to CLEAR.
  - Latch the target, x and initial weights into the output registers.
  - Clear `epoch_o` and `converged_o`.
- CLEAR: assert `zero_final_o` and `zero_loss_o` for one cycle, then go to FWD.
- FWD: assert `en_o` for one cycle, then go to EVAL. The neuron captures x·w at this edge.
- EVAL: form `err = final_i − (target << 7)` as a signed 20-bit value. Then, in priority order:
  1. If `zero_end_check_i` is high or |err| ≤ TOL: set `converged_o`=1 and go to DONE.
  2. Else if `epoch_o` == MAX_EPOCHS: go to DONE with `converged_o`=0.
  3. Else: go to UPDATE.
- UPDATE: for each k with xk ≠ 0, apply the step, then increment `epoch_o` and go to FWD.
  - err > 0: wk ← max(wk − STEP, 0).
  - err < 0: wk ← min(wk + STEP, 255).
  - Weights whose xk = 0 are left unchanged.
- DONE: pulse `done_o` for one cycle, then go to IDLE.
- `start_i` is ignored while `busy_o` is high.
- Arithmetic and width rules:
  - Weights are unsigned and saturate at 0 and 255; they never wrap.
  - `epoch_o` never exceeds MAX_EPOCHS.
  - The error is computed at full width, so there is no truncation.

## Timing
- Reset values:
  - State is IDLE.
  - All outputs are 0, including the weights, x, target, `epoch_o` and `converged_o`.
- Reset has priority over every state. Reset during a run returns to IDLE on the next edge with no `done_o` pulse.
- Run latency:
  - `start_i` sampled in IDLE → CLEAR in the next cycle → `en_o` in the cycle after that.
  - Each epoch takes 3 cycles (FWD, EVAL, UPDATE).
  - A run that converges immediately takes 4 cycles from the start edge to `done_o`: CLEAR, FWD, EVAL, DONE.
  - A run with N updates takes 4 + 3N cycles.
- `en_o`, `zero_final_o`, `zero_loss_o` and `done_o` are registered-state decodes and never stay high for more than one consecutive cycle.
- `w*_o` changes only on the edge that leaves UPDATE or leaves IDLE on a start. It is therefore stable during FWD.

## Structure
- `neuron_ctrl_pkg` holds:
  - the state enum;
  - `TARGET_FRAC_BITS` = 7;
  - the widths: `X_W` = 10, `W_W` = 8, `FINAL_W` = 19, `ERR_W` = 20.
- Sub-module `weight_step` is a combinational saturating up/down stepper.
  - Inputs: w, dir, en.
  - Parameter: STEP.
  - It is instantiated once per weight.

## Test plan
- Exact target: target=2, x0=16, x1=0, w0=16, w1=0 → `done_o` 4 cycles after start, `converged_o`=1, `epoch_o`=0, `w0_o`=16.
- Converging run: target=2, x0=16, x1=0, w0=12, TOL=16 → w0 steps 12→13→14→15, then `converged_o`=1, `epoch_o`=3, w1 untouched, `done_o` at cycle 13.
- Saturation and give-up: target=15, x0=1, x1=0, w0=250 → `w0_o` holds at 255 after 5 updates, then `done_o` with `converged_o`=0 and `epoch_o`=15.
- Zero target: target=0, x0=0, x1=0 → `zero_end_check_i` high in EVAL, so `converged_o`=1 and `epoch_o`=0.
- Reset mid-run: assert `rst_i` during an UPDATE → next cycle all outputs are 0, state is IDLE and no `done_o` pulse occurs.
- Start while busy: pulse `start_i` during FWD with different x values → the run is unaffected, the latched x is unchanged and only one `done_o` pulse occurs.

Source files
------------

// File: rtl/neuron_ctrl_pkg.sv
// Shared types and widths for the output_neuron training controller.
// The state encoding and all datapath widths live here so that the top and the stepper agree.
package neuron_ctrl_pkg;

    localparam int TARGET_FRAC_BITS = 7;
    localparam int X_W              = 10;
    localparam int W_W              = 8;
    localparam int FINAL_W          = 19;
    localparam int ERR_W            = 20;
    localparam int TGT_W            = 4;
    localparam int EPOCH_W          = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FWD    = 3'd2,
        S_EVAL   = 3'd3,
        S_UPDATE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/weight_step.sv
// Combinational saturating up/down stepper for one unsigned 1.7 weight.
// When en is low the weight passes through untouched.
module weight_step
    import neuron_ctrl_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic [W_W-1:0] w,
    input  logic           dir,
    input  logic           en,
    output logic [W_W-1:0] w_next
);

    typedef logic [W_W:0] wide_t;
    localparam wide_t STEP_WIDE = wide_t'(STEP);

    // dir high steps up and clamps at full scale; dir low steps down and clamps at zero.
    function automatic logic [W_W-1:0] sat_step(input logic [W_W-1:0] w_in, input logic up);
        wide_t sum;
        wide_t w_wide;
        logic [W_W-1:0] res;
        w_wide = {1'b0, w_in};
        if (up) begin
            sum = w_wide + STEP_WIDE;
            res = sum[W_W] ? {W_W{1'b1}} : sum[W_W-1:0];
        end else begin
            sum = w_wide - STEP_WIDE;
            res = (w_wide < STEP_WIDE) ? {W_W{1'b0}} : sum[W_W-1:0];
        end
        return res;
    endfunction

    always_comb begin
        w_next = w;
        if (en) begin
            w_next = sat_step(w, dir);
        end
    end

endmodule

// File: rtl/neuron_train_ctrl.sv
// Training sequencer for the two-input output_neuron: clear, then repeat forward pass,
// error evaluation and sign-based weight update until within tolerance or out of epochs.
module neuron_train_ctrl
    import neuron_ctrl_pkg::*;
#(
    parameter int MAX_EPOCHS = 15,
    parameter int TOL        = 16,
    parameter int STEP       = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [TGT_W-1:0]   target_i,
    input  logic [X_W-1:0]     x0_i,
    input  logic [X_W-1:0]     x1_i,
    input  logic [W_W-1:0]     w0_init_i,
    input  logic [W_W-1:0]     w1_init_i,
    input  logic [FINAL_W-1:0] final_i,
    input  logic               zero_end_check_i,
    output logic               en_o,
    output logic               zero_final_o,
    output logic               zero_loss_o,
    output logic [X_W-1:0]     x0_o,
    output logic [X_W-1:0]     x1_o,
    output logic [W_W-1:0]     w0_o,
    output logic [W_W-1:0]     w1_o,
    output logic [TGT_W-1:0]   target_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               converged_o,
    output logic [EPOCH_W-1:0] epoch_o
);

    localparam logic [ERR_W-1:0]   TOL_MAG   = ERR_W'(TOL);
    localparam logic [EPOCH_W-1:0] EPOCH_MAX = EPOCH_W'(MAX_EPOCHS);

    state_t state_q;
    state_t state_d;

    logic signed [ERR_W-1:0] final_s;
    logic signed [ERR_W-1:0] target_s;
    logic signed [ERR_W-1:0] err;
    logic [ERR_W-1:0]        err_mag;
    logic                    converge;
    logic                    give_up;
    logic [W_W-1:0]          w0_next;
    logic [W_W-1:0]          w1_next;

    function automatic logic [ERR_W-1:0] abs_err(input logic signed [ERR_W-1:0] e);
        logic signed [ERR_W-1:0] neg;
        neg = -e;
        return e[ERR_W-1] ? $unsigned(neg) : $unsigned(e);
    endfunction

    // Both operands are zero-extended into the signed error width, so the subtraction is exact.
    assign final_s  = $signed({{(ERR_W-FINAL_W){1'b0}}, final_i});
    assign target_s = $signed({{(ERR_W-TGT_W-TARGET_FRAC_BITS){1'b0}}, target_o,
                               {TARGET_FRAC_BITS{1'b0}}});
    assign err      = final_s - target_s;
    assign err_mag  = abs_err(err);
    assign converge = zero_end_check_i || (err_mag <= TOL_MAG);
    assign give_up  = (epoch_o == EPOCH_MAX);

    // A negative error means the result is low, so weights step up.
    weight_step #(.STEP(STEP)) u_step_w0 (
        .w      (w0_o),
        .dir    (err[ERR_W-1]),
        .en     (x0_o != '0),
        .w_next (w0_next)
    );

    weight_step #(.STEP(STEP)) u_step_w1 (
        .w      (w1_o),
        .dir    (err[ERR_W-1]),
        .en     (x1_o != '0),
        .w_next (w1_next)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_i) state_d = S_CLEAR;
            S_CLEAR:  state_d = S_FWD;
            S_FWD:    state_d = S_EVAL;
            S_EVAL: begin
                if (converge || give_up) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: state_d = S_FWD;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o       = (state_q != S_IDLE);
        zero_final_o = (state_q == S_CLEAR);
        zero_loss_o  = (state_q == S_CLEAR);
        en_o         = (state_q == S_FWD);
        done_o       = (state_q == S_DONE);
    end

    // Run registers: operands latch on start, weights and epoch advance only when leaving UPDATE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x0_o        <= '0;
            x1_o        <= '0;
            w0_o        <= '0;
            w1_o        <= '0;
            target_o    <= '0;
            epoch_o     <= '0;
            converged_o <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        x0_o        <= x0_i;
                        x1_o        <= x1_i;
                        w0_o        <= w0_init_i;
                        w1_o        <= w1_init_i;
                        target_o    <= target_i;
                        epoch_o     <= '0;
                        converged_o <= 1'b0;
                    end
                end
                S_EVAL: begin
                    if (converge) begin
                        converged_o <= 1'b1;
                    end
                end
                S_UPDATE: begin
                    w0_o    <= w0_next;
                    w1_o    <= w1_next;
                    epoch_o <= epoch_o + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
